i2s_decoder: RTL

- I2S receiver; the receive-side counterpart of the team's I2S encoder. Accepts external BCLK/LRCLK/SDATA as plain inputs (no clock use) and oversamples them with i_mclk.
- Recovers one 16-bit left and one 16-bit right sample per frame and presents them as a pair with a one-cycle valid strobe.
- Sits at the I2S input pins in front of the DSP/mixer path. Target rates: 24.576 MHz MCLK, 6.144 MHz BCLK, 96 kHz LR, i.e. 4 MCLK cycles per BCLK.

---
 rtl/i2s_decoder_if.sv | 36 +++
 rtl/i2s_decoder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/i2s_decoder_if.sv
// I2S receive pins and the recovered stereo sample bus.
// master = decoder side, slave = pin driver / sample consumer.
interface i2s_decoder_if #(
    parameter int DATA_W = 16
);
    logic              i_bclk;
    logic              i_lrclk;
    logic              i_sdata;
    logic [DATA_W-1:0] o_data_l;
    logic [DATA_W-1:0] o_data_r;
    logic              o_valid;
    logic              o_err;
    logic              o_locked;

    modport master (
        input  i_bclk,
        input  i_lrclk,
        input  i_sdata,
        output o_data_l,
        output o_data_r,
        output o_valid,
        output o_err,
        output o_locked
    );

    modport slave (
        output i_bclk,
        output i_lrclk,
        output i_sdata,
        input  o_data_l,
        input  o_data_r,
        input  o_valid,
        input  o_err,
        input  o_locked
    );
endinterface

// File: rtl/i2s_decoder.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA on MCLK and
// recovers one left/right sample pair per frame.
module i2s_decoder #(
    parameter int DATA_W    = 16,
    parameter int MAX_SLOTS = 32
) (
    input logic         i_mclk,
    input logic         i_rst_x,
    i2s_decoder_if.master bus
);
    localparam int CNT_W = $clog2(MAX_SLOTS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SLOTS);

    logic [1:0]        bclk_sync;
    logic [1:0]        lrclk_sync;
    logic [1:0]        sdata_sync;
    logic              bclk_prev;

    logic              lr_prev;
    logic [CNT_W-1:0]  slot_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] left_shadow;
    logic              left_ok;
    logic              commit_pend;

    logic [DATA_W-1:0] data_l;
    logic [DATA_W-1:0] data_r;
    logic              valid;
    logic              err;
    logic              locked;

    logic              bclk;
    logic              lrclk;
    logic              sdata;
    logic              bclk_rise;
    logic              lr_change;
    logic              data_slot;
    logic              last_slot;
    logic              short_word;
    logic [DATA_W-1:0] shift_next;

    assign bclk  = bclk_sync[1];
    assign lrclk = lrclk_sync[1];
    assign sdata = sdata_sync[1];

    assign bclk_rise  = bclk & ~bclk_prev;
    assign lr_change  = lrclk ^ lr_prev;
    // slot_cnt holds the index of the slot the next rise delivers
    assign data_slot  = (slot_cnt >= CNT_ONE) && (slot_cnt <= CNT_LAST);
    assign last_slot  = (slot_cnt == CNT_LAST);
    assign short_word = lr_change && data_slot;
    assign shift_next = {shift_reg[DATA_W-2:0], sdata};

    // Identical depth on all three pins keeps them cycle-aligned
    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            bclk_sync  <= 2'b00;
            lrclk_sync <= 2'b00;
            sdata_sync <= 2'b00;
            bclk_prev  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[0], bus.i_bclk};
            lrclk_sync <= {lrclk_sync[0], bus.i_lrclk};
            sdata_sync <= {sdata_sync[0], bus.i_sdata};
            bclk_prev  <= bclk;
        end
    end

    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            lr_prev   <= 1'b0;
            slot_cnt  <= CNT_MAX;
            shift_reg <= '0;
        end else if (bclk_rise) begin
            lr_prev <= lrclk;
            if (lr_change) begin
                slot_cnt <= CNT_ONE;
            end else begin
                if (slot_cnt != CNT_MAX) begin
                    slot_cnt <= slot_cnt + CNT_ONE;
                end
                if (data_slot) begin
                    shift_reg <= shift_next;
                end
            end
        end
    end

    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            left_shadow <= '0;
            left_ok     <= 1'b0;
            commit_pend <= 1'b0;
            data_l      <= '0;
            data_r      <= '0;
            valid       <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b0;
        end else begin
            valid       <= 1'b0;
            err         <= 1'b0;
            commit_pend <= 1'b0;
            if (commit_pend) begin
                data_l <= left_shadow;
                data_r <= shift_reg;
                valid  <= 1'b1;
                locked <= 1'b1;
            end
            if (bclk_rise) begin
                if (short_word) begin
                    err    <= 1'b1;
                    locked <= 1'b0;
                    if (lr_prev) begin
                        left_ok <= 1'b0;
                    end
                end else if (!lr_change && last_slot) begin
                    if (!lrclk) begin
                        left_shadow <= shift_next;
                        left_ok     <= 1'b1;
                    end else begin
                        // right word lands in shift_reg on this edge
                        commit_pend <= left_ok;
                        left_ok     <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.o_data_l = data_l;
    assign bus.o_data_r = data_r;
    assign bus.o_valid  = valid;
    assign bus.o_err    = err;
    assign bus.o_locked = locked;
endmodule
